// File: rtl/uart_rx_fifo_if.sv
// UART receive FIFO bus: receiver capture handshake plus consumer pop side.
// The FIFO binds the slave view; the environment driving it binds master.
interface uart_rx_fifo_if #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 8
);
    logic                     iRxFlag;
    logic [WORD_LENGTH-1:0]   iRxData;
    logic                     iParityError;
    logic                     oClearRxFlag;
    logic                     iRead;
    logic [WORD_LENGTH-1:0]   oData;
    logic                     oDataParityError;
    logic                     oEmpty;
    logic                     oFull;
    logic [$clog2(DEPTH):0]   oCount;
    logic                     oOverflow;
    logic                     iClearOverflow;

    modport master (
        output iRxFlag, iRxData, iParityError, iRead, iClearOverflow,
        input  oClearRxFlag, oData, oDataParityError,
        input  oEmpty, oFull, oCount, oOverflow
    );

    modport slave (
        input  iRxFlag, iRxData, iParityError, iRead, iClearOverflow,
        output oClearRxFlag, oData, oDataParityError,
        output oEmpty, oFull, oCount, oOverflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures one word per receiver flag, first-word
// fall-through read side, sticky overflow when a word cannot be stored.
module uart_rx_fifo #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_CLR
    } state_t;

    state_t state;
    state_t nextState;

    logic [WORD_LENGTH:0] mem [DEPTH];
    logic [PtrW-1:0]      rdPtr;
    logic [PtrW-1:0]      wrPtr;
    logic [CntW-1:0]      count;
    logic                 overflow;
    logic                 clearFlag;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CntW'(DEPTH));
    assign pop   = bus.iRead && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = (state == WRITE) && (!full || pop);
    assign drop  = (state == WRITE) && full && !pop;

    // Capture FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Capture FSM next state; clear request held until the flag drops.
    always_comb begin
        nextState = state;
        clearFlag = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.iRxFlag) nextState = WRITE;
            end
            WRITE: begin
                nextState = WAIT_CLR;
            end
            WAIT_CLR: begin
                clearFlag = 1'b1;
                if (!bus.iRxFlag) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Storage array; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= {bus.iParityError, bus.iRxData};
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Occupancy: push and pop together cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Sticky overflow; a new loss wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.iClearOverflow) begin
            overflow <= 1'b0;
        end
    end

    assign bus.oData            = mem[rdPtr][WORD_LENGTH-1:0];
    assign bus.oDataParityError = mem[rdPtr][WORD_LENGTH];
    assign bus.oEmpty           = empty;
    assign bus.oFull            = full;
    assign bus.oCount           = count;
    assign bus.oOverflow        = overflow;
    assign bus.oClearRxFlag     = clearFlag;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference plus directed literal
// checks around capture, ordering, overflow, parity and reset.
module tb_uart_rx_fifo;
    localparam int WL = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_rx_fifo_if #(.WORD_LENGTH(WL), .DEPTH(DP)) bus ();

    uart_rx_fifo #(.WORD_LENGTH(WL), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int clrPct = 0;

    // Reference: a FIFO queue plus the receiver handshake bookkeeping.
    logic [WL:0]   mq[$];
    logic [WL-1:0] popLog[$];
    bit armed = 1'b1;
    bit writeNext = 1'b0;
    bit mOvf = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Reference update on each active edge (or immediately on reset).
    always @(posedge clk or posedge reset) begin : model
        bit pop;
        bit full;
        if (reset) begin
            mq.delete();
            armed = 1'b1;
            writeNext = 1'b0;
            mOvf = 1'b0;
        end else begin
            pop = bus.iRead && (mq.size() > 0);
            full = (mq.size() == DP);
            if (writeNext && full && !pop) mOvf = 1'b1;
            else if (bus.iClearOverflow) mOvf = 1'b0;
            if (pop) begin
                popLog.push_back(mq[0][WL-1:0]);
                void'(mq.pop_front());
            end
            if (writeNext && (!full || pop))
                mq.push_back({bus.iParityError, bus.iRxData});
            if (writeNext) begin
                writeNext = 1'b0;
            end else if (armed && bus.iRxFlag) begin
                armed = 1'b0;
                writeNext = 1'b1;
            end else if (!armed && !bus.iRxFlag) begin
                armed = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the edge.
    always @(negedge clk) begin
        chk("count", int'(bus.oCount), mq.size());
        chk("empty", bus.oEmpty, int'(mq.size() == 0));
        chk("full", bus.oFull, int'(mq.size() == DP));
        chk("overflow", bus.oOverflow, mOvf);
        chk("clearRxFlag", bus.oClearRxFlag, int'(!armed && !writeNext));
        if (mq.size() > 0) begin
            chk("data", bus.oData, mq[0][WL-1:0]);
            chk("parity", bus.oDataParityError, mq[0][WL]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic pickRead(input int pct, input bit atWrite);
        if (pct < 0) return atWrite;
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic sendWord(input logic [WL-1:0] d, input logic p,
                            input int hold, input int rdPct);
        bus.iRxData = d;
        bus.iParityError = p;
        bus.iRxFlag = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.iRead = pickRead(rdPct, i == 1);
            bus.iClearOverflow = ($urandom_range(0, 99) < clrPct);
            tick();
            if (i >= 1) begin
                bus.iRxData = WL'($urandom);
                bus.iParityError = 1'($urandom);
            end
        end
        bus.iRxFlag = 1'b0;
        bus.iRead = pickRead(rdPct, 1'b0);
        tick();
        bus.iRead = 1'b0;
        bus.iClearOverflow = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DP + 4 && !bus.oEmpty; i++) begin
            bus.iRead = 1'b1;
            tick();
        end
        bus.iRead = 1'b0;
        chk("drainEmpty", bus.oEmpty, 1);
    endtask

    initial begin
        bus.iRxFlag = 1'b0;
        bus.iRxData = '0;
        bus.iParityError = 1'b0;
        bus.iRead = 1'b0;
        bus.iClearOverflow = 1'b0;
        repeat (3) tick();
        chk("rstEmpty", bus.oEmpty, 1);
        chk("rstCount", int'(bus.oCount), 0);
        chk("rstFull", bus.oFull, 0);
        chk("rstOvf", bus.oOverflow, 0);
        chk("rstClr", bus.oClearRxFlag, 0);
        reset = 1'b0;
        tick();

        // Single word with a long flag: latency and exactly one entry.
        bus.iRxData = 8'hA5;
        bus.iParityError = 1'b0;
        bus.iRxFlag = 1'b1;
        tick();
        chk("latEmpty1", bus.oEmpty, 1);
        tick();
        chk("latEmpty2", bus.oEmpty, 0);
        tick();
        chk("a5ClrHigh", bus.oClearRxFlag, 1);
        repeat (2) tick();
        chk("a5ClrHold", bus.oClearRxFlag, 1);
        bus.iRxFlag = 1'b0;
        tick();
        chk("a5ClrLow", bus.oClearRxFlag, 0);
        chk("a5Data", bus.oData, 8'hA5);
        chk("a5Count", int'(bus.oCount), 1);
        chk("a5Par", bus.oDataParityError, 0);
        drain();

        // Ordering through pointer wrap, never filling.
        popLog.delete();
        for (int k = 1; k <= 12; k++) sendWord(WL'(k), 1'b0, 2, -1);
        drain();
        chk("orderLen", popLog.size(), 12);
        for (int k = 0; k < 12 && k < popLog.size(); k++)
            chk("orderWord", popLog[k], k + 1);
        chk("orderOvf", bus.oOverflow, 0);

        // Overflow: ninth word lost, sticky flag, then cleared.
        popLog.delete();
        for (int k = 0; k < 9; k++) begin
            sendWord(WL'(8'h10 + k), 1'b0, 2, 0);
            if (k == 7) begin
                chk("ovfFull8", bus.oFull, 1);
                chk("ovfFlag8", bus.oOverflow, 0);
            end
        end
        chk("ovfFlag9", bus.oOverflow, 1);
        chk("ovfCount9", int'(bus.oCount), 8);
        drain();
        chk("ovfLen", popLog.size(), 8);
        for (int k = 0; k < 8 && k < popLog.size(); k++)
            chk("ovfWord", popLog[k], 8'h10 + k);
        bus.iClearOverflow = 1'b1;
        tick();
        bus.iClearOverflow = 1'b0;
        chk("ovfCleared", bus.oOverflow, 0);

        // Full FIFO with a pop in the write cycle keeps the new word.
        for (int k = 0; k < 8; k++) sendWord(WL'(8'h20 + k), 1'b0, 2, 0);
        sendWord(8'h99, 1'b0, 2, -1);
        chk("fullPopCount", int'(bus.oCount), 8);
        chk("fullPopOvf", bus.oOverflow, 0);
        popLog.delete();
        drain();
        chk("fullPopLen", popLog.size(), 8);
        if (popLog.size() > 0) begin
            chk("fullPopFirst", popLog[0], 8'h21);
            chk("fullPopLast", popLog[popLog.size() - 1], 8'h99);
        end

        // Parity flag travels with the word; reading empty is harmless.
        sendWord(8'h3C, 1'b1, 3, 0);
        chk("parData", bus.oData, 8'h3C);
        chk("parFlag", bus.oDataParityError, 1);
        drain();
        bus.iRead = 1'b1;
        repeat (3) tick();
        bus.iRead = 1'b0;
        chk("emptyReadCount", int'(bus.oCount), 0);
        chk("emptyReadEmpty", bus.oEmpty, 1);

        // Asynchronous reset while waiting for the flag to drop.
        sendWord(8'h51, 1'b0, 2, 0);
        sendWord(8'h52, 1'b0, 2, 0);
        bus.iRxData = 8'h77;
        bus.iRxFlag = 1'b1;
        repeat (2) tick();
        chk("midCount", int'(bus.oCount), 3);
        chk("midClr", bus.oClearRxFlag, 1);
        #1 reset = 1'b1;
        #1;
        chk("midRstClr", bus.oClearRxFlag, 0);
        chk("midRstCount", int'(bus.oCount), 0);
        chk("midRstEmpty", bus.oEmpty, 1);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("recapCount", int'(bus.oCount), 1);
        chk("recapData", bus.oData, 8'h77);
        bus.iRxFlag = 1'b0;
        repeat (2) tick();
        drain();

        // Random traffic: busy reader first, then a slow one that overflows.
        clrPct = 10;
        for (int n = 0; n < 80; n++)
            sendWord(WL'($urandom), 1'($urandom),
                     $urandom_range(2, 5), (n < 40) ? 60 : 8);
        clrPct = 0;
        drain();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8: received data width; matches the UART receiver word width.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock, the receiver-side clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port iRxData, input, WORD_LENGTH: received byte from the UART receiver.
REQ-006 SHALL have port iRxFlag, input, 1: level high while the receiver holds a new word.
REQ-007 SHALL have port iParityError, input, 1: parity error status of the word on iRxData.
REQ-008 SHALL have port oClearRxFlag, output, 1: active-high request telling the receiver to drop iRxFlag.
REQ-009 SHALL have port iRead, input, 1: consumer pop strobe.
REQ-010 SHALL have port oData, output, WORD_LENGTH: head-of-FIFO word (first-word fall-through).
REQ-011 SHALL have port oDataParityError, output, 1: parity flag stored with the head word.
REQ-012 SHALL have ports oEmpty and oFull, output, 1 each: FIFO status.
REQ-013 SHALL have port oCount, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-014 SHALL have port oOverflow, output, 1: sticky, set when a word is lost.
REQ-015 SHALL have port iClearOverflow, input, 1: synchronous clear of oOverflow.

Function
REQ-016 SHALL use a capture FSM with states IDLE, WRITE and WAIT_CLR.
REQ-017 IDLE -> WRITE on iRxFlag=1; no other transition out of IDLE.
REQ-018 WRITE SHALL last exactly 1 cycle.
- Action: push {iParityError, iRxData} as sampled in WRITE, if not full or if a pop occurs in the same cycle.
- Next state: WAIT_CLR.
REQ-019 WAIT_CLR SHALL drive oClearRxFlag=1.
- Stay while iRxFlag=1.
- Return to IDLE on the first cycle iRxFlag=0.
- oClearRxFlag=0 in every other state.
REQ-020 SHALL capture exactly one word per iRxFlag assertion, however long iRxFlag stays high.
REQ-021 Data SHALL be visible on oData with oEmpty=0 one cycle after WRITE; latency from iRxFlag rise to oEmpty falling is 2 cycles.
REQ-022 Pop SHALL occur when iRead=1 and oEmpty=0.
- Effect: head pointer advances; the next word appears on oData the following cycle.
- iRead while empty SHALL be ignored, with no state change.
REQ-023 Simultaneous push and pop SHALL leave oCount unchanged, including when full; the pushed word is retained.
REQ-024 Push when full without a pop SHALL drop the word and set oOverflow=1.
- Stored data is unchanged.
- The FSM still proceeds to WAIT_CLR.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 Status outputs SHALL follow these rules:
- oCount increments on push only and decrements on pop only.
- oEmpty = (oCount==0); oFull = (oCount==DEPTH).
REQ-027 iClearOverflow=1 SHALL clear oOverflow next cycle; if an overflow occurs in the same cycle, set takes priority.
REQ-028 oData and oDataParityError SHALL be don't-care while oEmpty=1.

Reset
REQ-029 On reset=1, asynchronously and regardless of clk:
- FSM -> IDLE; pointers -> 0; oCount -> 0.
- oEmpty=1, oFull=0, oOverflow=0, oClearRxFlag=0.
- Storage contents need not be cleared.
REQ-030 Reset mid-WAIT_CLR SHALL drop oClearRxFlag immediately.
- If iRxFlag is still high after reset release, IDLE -> WRITE recaptures that word.
- This is accepted behaviour.

Verification
REQ-031 Single word: iRxData=8'hA5, iRxFlag held high for 5 cycles -> one entry.
- oClearRxFlag=1 until iRxFlag falls.
- oData=8'hA5, oCount=1, oEmpty=0, oDataParityError=0.
REQ-032 Order and wrap: push 8'h01..8'h0C (DEPTH=8), popping so the queue never fills -> pops return 01..0C in order, oOverflow=0.
REQ-033 Overflow: push 9 words 8'h10..8'h18 with no reads.
- oFull=1 after the 8th push.
- oOverflow=1 after the 9th push.
- Pops return 10..17; 18 is lost.
- iClearOverflow pulse -> oOverflow=0.
REQ-034 Full with simultaneous pop: FIFO full, iRead=1 in the same cycle as WRITE of 8'h99 -> oCount stays 8, 8'h99 is the last word popped.
REQ-035 Parity and empty read: push 8'h3C with iParityError=1 -> oDataParityError=1 at the head; iRead on an empty FIFO -> oCount stays 0, no underflow.
REQ-036 Reset mid-operation: assert reset during WAIT_CLR with 3 entries stored -> same cycle oClearRxFlag=0, oCount=0, oEmpty=1.
